// File: rtl/seq_multiplier_if.sv
// Start/Busy/Done handshake bundle for seq_multiplier: operands in, double-width product out.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 8
);
  logic                   Start;
  logic                   SignedMode;
  logic [WIDTH-1:0]       Multiplicand;
  logic [WIDTH-1:0]       Multiplier;
  logic [2*WIDTH-1:0]     Product;
  logic                   Busy;
  logic                   Done;

  modport master (
    output Start, SignedMode, Multiplicand, Multiplier,
    input  Product, Busy, Done
  );

  modport slave (
    input  Start, SignedMode, Multiplicand, Multiplier,
    output Product, Busy, Done
  );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per clock, signed or unsigned.
// Optional SEQ_MULT_ZERO_SKIP_EN: a zero operand finishes in one cycle without running.
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  seq_multiplier_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sgn_q, sgn_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic                 accept;
  logic                 zero_op;
  logic                 last;
  logic [WIDTH:0]       addend;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       shifted_a;
  logic [WIDTH-1:0]     shifted_q;

  always_comb begin
    accept = bus.Start && (state_q != RUN);
    last   = (cnt_q == LAST);
`ifdef SEQ_MULT_ZERO_SKIP_EN
    zero_op = (bus.Multiplicand == '0) || (bus.Multiplier == '0);
`else
    zero_op = 1'b0;
`endif
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = zero_op ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The final signed iteration subtracts M: the multiplier's MSB carries weight -2^(WIDTH-1).
  always_comb begin
    addend    = '0;
    if (q_q[0]) begin
      addend = (last && sgn_q) ? (~m_q + 1'b1) : m_q;
    end
    sum       = a_q + addend;
    shifted_a = {(sgn_q ? sum[WIDTH] : 1'b0), sum[WIDTH:1]};
    shifted_q = {sum[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    product_d = product_q;
    if (accept) begin
      a_d   = '0;
      q_d   = bus.Multiplier;
      m_d   = {(bus.SignedMode ? bus.Multiplicand[WIDTH-1] : 1'b0), bus.Multiplicand};
      cnt_d = '0;
      sgn_d = bus.SignedMode;
      if (zero_op) begin
        product_d = '0;
      end
    end else if (state_q == RUN) begin
      a_d   = shifted_a;
      q_d   = shifted_q;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        product_d = {shifted_a[WIDTH-1:0], shifted_q};
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      product_q <= '0;
    end else begin
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    bus.Busy    = (state_q == RUN);
    bus.Done    = (state_q == DONE);
    bus.Product = product_q;
  end

endmodule
